instr_fetch_unit: RTL

//  Fetch-side initiator for the instruction ROM: owns the PC, drives imem_address,

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_if.sv | 29 ++
 rtl/fetch_buf.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 90 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg: shared widths and fetch buffer entry type               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_if: ROM fetch port, decode handshake and redirect signals    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface fetch_if;

  logic [fetch_pkg::ADDR_W-1:0]  imem_address;
  logic [fetch_pkg::INSTR_W-1:0] imem_instr;
  logic                          out_valid;
  logic                          out_ready;
  logic [fetch_pkg::ADDR_W-1:0]  out_pc;
  logic [fetch_pkg::INSTR_W-1:0] out_instr;
  logic                          redirect_valid;
  logic [fetch_pkg::ADDR_W-1:0]  redirect_pc;
  logic                          fetch_fault;

  modport master (
    output imem_address, out_valid, out_pc, out_instr, fetch_fault,
    input  imem_instr, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_address, out_valid, out_pc, out_instr, fetch_fault,
    output imem_instr, out_ready, redirect_valid, redirect_pc
  );

endinterface
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_buf: 2-entry circular FIFO of fetch entries, flush dominates |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  input  wire logic         flush_i,
  input  wire logic         push_i,
  input  wire logic         pop_i,
  input  wire fetch_entry_t data_i,
  output fetch_entry_t      head_o,
  output logic              full_o,
  output logic              empty_o
);

  fetch_entry_t mem_q [DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         pop_eff;
  logic         push_eff;

  assign full_o   = (count_q == 2'(DEPTH));
  assign empty_o  = (count_q == 2'd0);
  assign head_o   = mem_q[rd_ptr_q];
  assign pop_eff  = pop_i & ~empty_o;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign push_eff = push_i & (~full_o | pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_eff) wr_ptr_d = ~wr_ptr_q;
      if (pop_eff)  rd_ptr_d = ~rd_ptr_q;
      if (push_eff & ~pop_eff)      count_d = count_q + 2'd1;
      else if (pop_eff & ~push_eff) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_eff & ~flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_unit: PC owner feeding decode from a combinational ROM |
// | Optional bounds/alignment fault: define FETCH_BOUNDS_CHECK_EN       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 1024,
  parameter int          BUF_DEPTH  = 2
) (
  input  wire logic clk,
  input  wire logic reset_n,
  fetch_if.master   bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  fetch_entry_t      hold_q, hold_d;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              buf_full;
  logic              buf_empty;
  logic              pop;
  logic              push;
  logic              oob;
  logic              redirect_fault;

`ifdef FETCH_BOUNDS_CHECK_EN
  // No fetch is attempted in a redirect cycle, so the old pc cannot fault then.
  assign oob            = ~bus.redirect_valid & (pc_q >= 64'(IMEM_BYTES - 3));
  assign redirect_fault = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
`else
  logic unused_cfg;
  assign oob            = 1'b0;
  assign redirect_fault = 1'b0;
  assign unused_cfg     = &{1'b0, bus.redirect_pc[1:0], (IMEM_BYTES > 0)};
`endif

  assign pop        = ~buf_empty & bus.out_ready;
  assign push       = ~bus.redirect_valid & (~buf_full | pop) & ~fault_q & ~oob;
  assign push_entry = {pc_q, bus.imem_instr};

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (bus.redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .head_o  (head),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    hold_d  = hold_q;
    if (!buf_empty) hold_d = head;
    if (bus.redirect_valid) pc_d = {bus.redirect_pc[63:2], 2'b00};
    else if (push)          pc_d = pc_q + 64'd4;
    if (oob | redirect_fault) fault_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      hold_q  <= hold_d;
    end
  end

  // While empty, decode keeps seeing the last head rather than a stale slot.
  assign bus.imem_address = pc_q;
  assign bus.out_valid    = ~buf_empty;
  assign bus.out_pc       = buf_empty ? hold_q.pc    : head.pc;
  assign bus.out_instr    = buf_empty ? hold_q.instr : head.instr;
  assign bus.fetch_fault  = fault_q;

endmodule
`default_nettype wire
